// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared state encoding and time constants for the clock controller
package clock_pkg;

    // Controller modes; the encoding is also driven out on the mode port.
    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_SET_MIN = 2'd1,
        ST_SET_HR  = 2'd2
    } clock_state_t;

    // Default auto-repeat delay and SET-mode inactivity timeout, in 1 Hz ticks.
    localparam int DEF_REPEAT_TICKS  = 2;
    localparam int DEF_TIMEOUT_TICKS = 30;

    // Terminal counts used by the seconds/minutes counters for their wrap flags.
    localparam int MAX_SEC = 59;
    localparam int MAX_MIN = 59;

    // Mode-button sequencing: RUN -> SET_MIN -> SET_HR -> RUN.
    function automatic clock_state_t mode_step(input clock_state_t s);
        case (s)
            ST_RUN:     return ST_SET_MIN;
            ST_SET_MIN: return ST_SET_HR;
            default:    return ST_RUN;
        endcase
    endfunction

    // True in either of the time-setting modes.
    function automatic logic is_set_state(input clock_state_t s);
        return (s == ST_SET_MIN) || (s == ST_SET_HR);
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// rtl/btn_sync_edge.sv - button synchronizer with registered rising-edge press pulse
module btn_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic press
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   level_d;

    // Metastability chain: the raw button ripples through SYNC_STAGES flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= btn;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign level = sync_q[SYNC_STAGES-1];

    // Registered rising-edge detect on the synchronized level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_d <= 1'b0;
            press   <= 1'b0;
        end else begin
            level_d <= level;
            press   <= level & ~level_d;
        end
    end

endmodule

// File: rtl/clock_set_ctrl.sv
// rtl/clock_set_ctrl.sv - clock mode controller and counter increment scheduler
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int REPEAT_TICKS  = DEF_REPEAT_TICKS,
    parameter int TIMEOUT_TICKS = DEF_TIMEOUT_TICKS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       sec_wrap,
    input  logic       min_wrap,
    output logic       sec_inc,
    output logic       sec_clr,
    output logic       min_inc,
    output logic       hr_inc,
    output logic [1:0] mode,
    output logic       blink
);

    // Counters are wide enough to hold their terminal value.
    localparam int REP_W = $clog2(REPEAT_TICKS + 1);
    localparam int TO_W  = $clog2(TIMEOUT_TICKS + 1);

    logic mode_press;
    logic mode_level_unused;
    logic inc_press;
    logic inc_level;

    clock_state_t     state;
    clock_state_t     state_nxt;
    logic [REP_W-1:0] rep_cnt;
    logic [REP_W-1:0] rep_cnt_nxt;
    logic [TO_W-1:0]  to_cnt;
    logic [TO_W-1:0]  to_cnt_nxt;

    logic in_set;
    logic state_chg;
    logic rep_fire;
    logic inc_evt;
    logic timeout_hit;
    logic sec_inc_nxt;
    logic sec_clr_nxt;
    logic min_inc_nxt;
    logic hr_inc_nxt;
    logic blink_nxt;

    btn_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_mode (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_mode),
        .level (mode_level_unused),
        .press (mode_press)
    );

    btn_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_inc (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_inc),
        .level (inc_level),
        .press (inc_press)
    );

    // Next-state, counter and output decode from the state held this cycle.
    always_comb begin
        in_set      = is_set_state(state);

        // A held button produces one increment per tick once the hold delay has elapsed.
        rep_fire    = in_set && inc_level && tick_1hz &&
                      (rep_cnt == REP_W'(REPEAT_TICKS));

        // Mode press wins over any increment in the same cycle; press and repeat merge.
        inc_evt     = in_set && !mode_press && (inc_press || rep_fire);

        // Any increment activity in this cycle defers the timeout.
        timeout_hit = in_set && tick_1hz && !inc_press && !rep_fire &&
                      (to_cnt == TO_W'(TIMEOUT_TICKS - 1));

        state_nxt = state;
        if (mode_press) begin
            state_nxt = mode_step(state);
        end else if (timeout_hit) begin
            state_nxt = ST_RUN;
        end
        state_chg = (state_nxt != state);

        sec_inc_nxt = 1'b0;
        min_inc_nxt = 1'b0;
        hr_inc_nxt  = 1'b0;
        case (state)
            ST_RUN: begin
                // Normal time keeping: all carries land in the same cycle as sec_inc.
                sec_inc_nxt = tick_1hz;
                min_inc_nxt = tick_1hz && sec_wrap;
                hr_inc_nxt  = tick_1hz && sec_wrap && min_wrap;
            end
            ST_SET_MIN: begin
                min_inc_nxt = inc_evt;
            end
            ST_SET_HR: begin
                hr_inc_nxt = inc_evt;
            end
            default: begin
                sec_inc_nxt = 1'b0;
            end
        endcase

        // Seconds restart from zero whenever minute setting begins.
        sec_clr_nxt = (state == ST_RUN) && (state_nxt == ST_SET_MIN);

        rep_cnt_nxt = rep_cnt;
        if (!in_set || state_chg || !inc_level) begin
            rep_cnt_nxt = '0;
        end else if (tick_1hz && (rep_cnt != REP_W'(REPEAT_TICKS))) begin
            rep_cnt_nxt = rep_cnt + REP_W'(1);
        end

        to_cnt_nxt = to_cnt;
        if (!in_set || state_chg || mode_press || inc_press || rep_fire) begin
            to_cnt_nxt = '0;
        end else if (tick_1hz) begin
            to_cnt_nxt = to_cnt + TO_W'(1);
        end

        // Field blanking: off in RUN, starts visible-blank on entry, toggles each second.
        if (state_nxt == ST_RUN) begin
            blink_nxt = 1'b0;
        end else if (state_chg) begin
            blink_nxt = 1'b1;
        end else if (tick_1hz) begin
            blink_nxt = ~blink;
        end else begin
            blink_nxt = blink;
        end
    end

    // Mode FSM, counters and registered output pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_RUN;
            rep_cnt <= '0;
            to_cnt  <= '0;
            sec_inc <= 1'b0;
            sec_clr <= 1'b0;
            min_inc <= 1'b0;
            hr_inc  <= 1'b0;
            blink   <= 1'b0;
        end else begin
            state   <= state_nxt;
            rep_cnt <= rep_cnt_nxt;
            to_cnt  <= to_cnt_nxt;
            sec_inc <= sec_inc_nxt;
            sec_clr <= sec_clr_nxt;
            min_inc <= min_inc_nxt;
            hr_inc  <= hr_inc_nxt;
            blink   <= blink_nxt;
        end
    end

    assign mode = state;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb/tb_clock_set_ctrl.sv - scoreboard bench for clock_set_ctrl
module tb_clock_set_ctrl;

    localparam int SYNC = 2;
    localparam int REP  = 2;
    localparam int TOUT = 30;

    logic       clk;
    logic       rst;
    logic       tick_1hz;
    logic       btn_mode;
    logic       btn_inc;
    logic       sec_wrap;
    logic       min_wrap;
    logic       sec_inc;
    logic       sec_clr;
    logic       min_inc;
    logic       hr_inc;
    logic [1:0] mode;
    logic       blink;

    clock_set_ctrl #(
        .SYNC_STAGES   (SYNC),
        .REPEAT_TICKS  (REP),
        .TIMEOUT_TICKS (TOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tick_1hz (tick_1hz),
        .btn_mode (btn_mode),
        .btn_inc  (btn_inc),
        .sec_wrap (sec_wrap),
        .min_wrap (min_wrap),
        .sec_inc  (sec_inc),
        .sec_clr  (sec_clr),
        .min_inc  (min_inc),
        .hr_inc   (hr_inc),
        .mode     (mode),
        .blink    (blink)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;
    int cnt_sec  = 0;
    int cnt_min  = 0;
    int cnt_hr   = 0;
    int cnt_clr  = 0;

    logic [6:0] expq[$];

    // stimulus levels applied at the next step
    bit cur_rst, cur_bm, cur_binc, cur_sw, cur_mw;

    // reference model: mode, blink, ticks held / ticks idle, raw button history
    int m_mode, m_held, m_idle;
    bit m_blink;
    bit hist_m[$];
    bit hist_i[$];

    function automatic logic [6:0] outs();
        return {sec_inc, sec_clr, min_inc, hr_inc, mode, blink};
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_held = 0; m_idle = 0; m_blink = 1'b0;
        hist_m.delete(); hist_i.delete();
        for (int k = 0; k < SYNC + 3; k++) begin
            hist_m.push_back(1'b0);
            hist_i.push_back(1'b0);
        end
    endtask

    // One clock: drive inputs at negedge and push the outputs expected after the next posedge.
    task automatic step(input bit tk);
        bit mp, ip, il, rep, incv;
        bit e_sec, e_clr, e_min, e_hr;
        int nm, top;
        @(negedge clk);
        tick_1hz = tk; btn_mode = cur_bm; btn_inc = cur_binc;
        sec_wrap = cur_sw; min_wrap = cur_mw;
        if (cur_rst && !rst) begin
            rst = 1'b1;
            #1;
            chk("reset_immediate", int'(outs()), 0);
        end else begin
            rst = cur_rst;
        end
        if (cur_rst) begin
            model_reset();
            expq.push_back(7'd0);
        end else begin
            hist_m.push_back(cur_bm);
            hist_i.push_back(cur_binc);
            top = hist_m.size() - 1;
            // a raw edge reaches the controller SYNC+1 samples later; the level SYNC later
            mp = hist_m[top-SYNC-1] && !hist_m[top-SYNC-2];
            ip = hist_i[top-SYNC-1] && !hist_i[top-SYNC-2];
            il = hist_i[top-SYNC];
            void'(hist_m.pop_front());
            void'(hist_i.pop_front());
            e_sec = 0; e_clr = 0; e_min = 0; e_hr = 0; rep = 0;
            nm = m_mode;
            if (m_mode == 0) begin
                if (tk) begin
                    e_sec = 1'b1;
                    e_min = cur_sw;
                    e_hr  = cur_sw && cur_mw;
                end
                if (mp) nm = 1;
            end else begin
                rep  = tk && il && (m_held >= REP);
                incv = !mp && (ip || rep);
                if (incv) begin
                    if (m_mode == 1) e_min = 1'b1;
                    else             e_hr  = 1'b1;
                end
                if (mp) nm = (m_mode + 1) % 3;
                else if (tk && !ip && !rep && (m_idle + 1 >= TOUT)) nm = 0;
            end
            e_clr = (m_mode == 0) && (nm == 1);
            if (nm == 0 || nm != m_mode || !il) m_held = 0;
            else if (tk) m_held++;
            if (nm == 0 || nm != m_mode || mp || ip || rep) m_idle = 0;
            else if (tk) m_idle++;
            if (nm == 0) m_blink = 1'b0;
            else if (nm != m_mode) m_blink = 1'b1;
            else if (tk) m_blink = !m_blink;
            m_mode = nm;
            expq.push_back({e_sec, e_clr, e_min, e_hr, 2'(nm), m_blink});
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0);
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) begin
            step(1'b1);
            idle(3);
        end
    endtask

    task automatic press_mode();
        cur_bm = 1'b1; step(1'b0);
        cur_bm = 1'b0; idle(5);
    endtask

    task automatic press_inc();
        cur_binc = 1'b1; step(1'b0);
        cur_binc = 1'b0; idle(5);
    endtask

    // Monitor: compare every cycle's outputs against the scoreboard and tally pulses.
    initial begin
        logic [6:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                n_checks++;
                if (outs() !== e) begin
                    n_errors++;
                    $display("FAIL scoreboard at %0t: got sec,clr,min,hr,mode,blink=%b expected %b",
                             $time, outs(), e);
                end
            end
            cnt_sec += int'(sec_inc);
            cnt_min += int'(min_inc);
            cnt_hr  += int'(hr_inc);
            cnt_clr += int'(sec_clr);
        end
    end

    initial begin
        int s0, m0, h0, c0, rst_left;
        rst = 1'b1; tick_1hz = 0; btn_mode = 0; btn_inc = 0; sec_wrap = 0; min_wrap = 0;
        cur_rst = 1; cur_bm = 0; cur_binc = 0; cur_sw = 0; cur_mw = 0;
        model_reset();
        #1;
        chk("reset_state", int'(outs()), 0);
        idle(3);
        cur_rst = 0;
        idle(4);

        // RUN: three plain ticks
        s0 = cnt_sec; m0 = cnt_min; h0 = cnt_hr;
        ticks(3);
        chk("run_sec_count", cnt_sec - s0, 3);
        chk("run_min_none", cnt_min - m0, 0);
        chk("run_hr_none", cnt_hr - h0, 0);

        // RUN: full carry cascade
        cur_sw = 1; cur_mw = 1;
        s0 = cnt_sec; m0 = cnt_min; h0 = cnt_hr;
        ticks(1);
        chk("carry_sec", cnt_sec - s0, 1);
        chk("carry_min", cnt_min - m0, 1);
        chk("carry_hr", cnt_hr - h0, 1);

        // SET_MIN: entry clears seconds, inc presses do not carry, ticks are ignored
        cur_sw = 0;
        c0 = cnt_clr;
        press_mode();
        chk("enter_set_min", int'(mode), 1);
        chk("sec_clr_once", cnt_clr - c0, 1);
        chk("blink_on_entry", int'(blink), 1);
        m0 = cnt_min; h0 = cnt_hr; s0 = cnt_sec;
        press_inc();
        press_inc();
        chk("set_min_incs", cnt_min - m0, 2);
        chk("set_min_no_hr", cnt_hr - h0, 0);
        ticks(3);
        chk("set_min_no_sec", cnt_sec - s0, 0);

        // SET_HR: held inc gives the press plus repeats from the third tick on
        cur_mw = 0;
        press_mode();
        chk("enter_set_hr", int'(mode), 2);
        h0 = cnt_hr;
        cur_binc = 1; idle(5);
        ticks(5);
        cur_binc = 0; idle(4);
        chk("hold_hr_incs", cnt_hr - h0, 4);

        // Back to RUN, then SET_MIN timeout after 30 idle ticks
        press_mode();
        chk("back_to_run", int'(mode), 0);
        press_mode();
        ticks(29);
        chk("no_timeout_29", int'(mode), 1);
        ticks(1);
        chk("timeout_30", int'(mode), 0);
        chk("timeout_blink", int'(blink), 0);

        // Inc press landing on tick 29 restarts the timeout
        press_mode();
        ticks(28);
        m0 = cnt_min;
        cur_binc = 1; idle(3);
        step(1'b1);
        cur_binc = 0; idle(3);
        ticks(1);
        chk("activity_keeps_set", int'(mode), 1);
        chk("activity_min_inc", cnt_min - m0, 1);
        press_mode();
        press_mode();
        chk("run_again", int'(mode), 0);

        // Reset in SET_HR with inc held
        press_mode();
        press_mode();
        cur_binc = 1; idle(6);
        cur_rst = 1; idle(2);
        cur_rst = 0; idle(5);
        s0 = cnt_sec; m0 = cnt_min; h0 = cnt_hr; c0 = cnt_clr;
        ticks(1);
        chk("post_rst_sec", cnt_sec - s0, 1);
        chk("post_rst_min", cnt_min - m0, 0);
        chk("post_rst_hr", cnt_hr - h0, 0);
        chk("post_rst_no_clr", cnt_clr - c0, 0);
        cur_binc = 0; idle(4);

        // Randomized traffic, all checked by the scoreboard
        rst_left = 0;
        for (int k = 0; k < 4000; k++) begin
            if (cur_bm) cur_bm = ($urandom_range(0, 1) == 0);
            else        cur_bm = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 14) == 0) cur_binc = !cur_binc;
            cur_sw = ($urandom_range(0, 2) == 0);
            cur_mw = ($urandom_range(0, 2) == 0);
            if (rst_left > 0) begin
                rst_left--;
                if (rst_left == 0) cur_rst = 0;
            end else if ($urandom_range(0, 799) == 0) begin
                cur_rst = 1;
                rst_left = 2;
            end
            step($urandom_range(0, 4) == 0);
        end
        cur_rst = 0; cur_bm = 0; cur_binc = 0;
        idle(3);

        for (int k = 0; k < 10 && expq.size() != 0; k++) @(posedge clk);
        #2;
        chk("scoreboard_drained", expq.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/clock_set_ctrl.md
# clock_set_ctrl

Mode controller and increment scheduler for the digital clock's seconds/minutes/hours counters. It runs on the fast system clock and consumes the one-cycle 1 Hz strobe and two raw push-buttons. It then issues single-cycle increment/clear pulses to the counters' enable inputs. In RUN it sequences the normal carry cascade; in SET_MIN/SET_HR it redirects button presses to the selected counter and blinks that display field.

## Interface
- SYNC_STAGES, 2, synchronizer depth for each button input
- REPEAT_TICKS, 2, 1 Hz ticks of continuous inc hold before auto-repeat starts
- TIMEOUT_TICKS, 30, 1 Hz ticks without any button edge before a SET mode returns to RUN
- clk  in  1  system clock; all logic on posedge
- rst  in  1  asynchronous, active-high reset
- tick_1hz  in  1  one-cycle strobe, once per second, synchronous to clk
- btn_mode  in  1  raw mode button, active-high, asynchronous
- btn_inc  in  1  raw increment button, active-high, asynchronous
- sec_wrap  in  1  seconds counter currently at 59
- min_wrap  in  1  minutes counter currently at 59
- sec_inc  out  1  one-cycle seconds increment pulse
- sec_clr  out  1  one-cycle seconds clear pulse
- min_inc  out  1  one-cycle minutes increment pulse
- hr_inc  out  1  one-cycle hours increment pulse
- mode  out  2  current state: 0 RUN, 1 SET_MIN, 2 SET_HR
- blink  out  1  display blank strobe for the field being set

## Operation
- Each button: SYNC_STAGES-flop synchronizer, then rising-edge detect (one-cycle press pulse). No debounce here; upstream filtering provided.
- States: RUN -> (mode press) SET_MIN -> (mode press) SET_HR -> (mode press) RUN. From either SET state, timeout -> RUN.
- Entering SET_MIN: sec_clr pulses for exactly one cycle, the cycle after the transition.
- RUN, on tick_1hz: sec_inc=1. If sec_wrap, min_inc=1 same cycle. If sec_wrap and min_wrap, hr_inc=1 same cycle. inc presses ignored.
- SET_MIN: tick_1hz never produces sec_inc. inc press -> min_inc only; no carry to hours, even with min_wrap=1.
- SET_HR: inc press -> hr_inc. sec_inc/min_inc stay 0.
- Auto-repeat: while synchronized btn_inc stays high in a SET state, count ticks. Once REPEAT_TICKS ticks have elapsed, every further tick issues one increment to the selected field.
- Timeout counter: clears on any press (mode or inc) and on every state change. Increments on tick_1hz in SET states. Reaching TIMEOUT_TICKS forces RUN on that tick cycle.
- Auto-repeat ticks count as activity, so a held inc button never times out.
- blink: 0 in RUN. In SET states it toggles on each tick_1hz and is forced to 1 on entry.
- Simultaneous events:
  - Outputs are decoded from the state held at the start of the cycle.
  - Mode press + tick in RUN: the tick's RUN increments are still issued, and the state changes next cycle.
  - Mode press + inc press in a SET state: the mode press wins and no increment is issued.
  - Timeout and mode press in the same cycle: the mode press wins.
  - Inc press and repeat tick in the same cycle: exactly one increment.

## Timing
- Reset values: mode=0 (RUN); blink=0; all pulse outputs 0; synchronizers, repeat and timeout counters cleared.
- Raw button to press pulse: SYNC_STAGES+1 clk cycles.
- Press pulse to inc/mode effect: outputs registered, +1 cycle.
- tick_1hz to sec_inc/min_inc/hr_inc: 1 cycle, all carries aligned in the same cycle.
- Every output pulse is exactly one cycle wide. sec_inc, min_inc and hr_inc never assert on consecutive cycles from a single event.
- Reset asserted mid-SET: immediate return to RUN with all outputs 0. No sec_clr is generated on reset release.

## Structure
- Shared package clock_pkg:
  - state enum (RUN/SET_MIN/SET_HR, 2-bit)
  - default REPEAT_TICKS/TIMEOUT_TICKS constants
  - MAX_SEC=59 and MAX_MIN=59 constants, for reuse by the counters' wrap comparisons
- Sub-module btn_sync_edge (synchronizer + rising-edge detect, parameterized SYNC_STAGES), instantiated twice.
- Repeat and timeout counters sized by $clog2 of their parameters.

## Test plan
- Reset, RUN, 3 ticks with sec_wrap=0 -> three single-cycle sec_inc pulses, each 1 cycle after its tick; min_inc=hr_inc=0 throughout.
- RUN tick with sec_wrap=1 and min_wrap=1 -> sec_inc, min_inc and hr_inc all high in the same cycle, then all 0.
- Mode press -> mode=1, sec_clr one cycle. 2 inc presses with min_wrap=1 -> 2 min_inc pulses, hr_inc=0. Ticks -> no sec_inc.
- SET_HR, hold btn_inc across 5 ticks (REPEAT_TICKS=2) -> 1 hr_inc from the press plus 3 repeat hr_inc pulses, on ticks 3, 4 and 5.
- SET_MIN, no buttons for 30 ticks -> mode=0 on tick 30; blink=0. Repeat with an inc press at tick 29 -> still in SET_MIN at tick 30.
- Assert rst while in SET_HR with btn_inc held -> mode=0 and all outputs 0 immediately. After release, 1 tick -> sec_inc only.
